// File: rtl/cpu_sequencer_if.sv
// Memory-bus interface between cpu_sequencer (master) and a memory (slave).
// A transfer is offered with mem_req held high together with stable mem_we/mem_addr/mem_wdata
// and completes on the first rising edge where mem_ack is also high; read data is valid
// alongside mem_ack in that same cycle.
//   mem_req   master->slave  request, held until acknowledged
//   mem_we    master->slave  1 = store, 0 = read
//   mem_addr  master->slave  byte address
//   mem_wdata master->slave  store data
//   mem_ack   slave->master  acknowledge
//   mem_rdata slave->master  read data
interface cpu_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle stage sequencer for the RISC-V core. Owns PC, IR and the memory-bus master and
// steps FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK, with a req/ack memory handshake
// tolerating any number of wait states, branch redirect, halt, a sticky misaligned-target
// fault and a wrapping retired-instruction counter.
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-low reset
//   mem_io          memory-bus master (see cpu_sequencer_if)
//   is_mem_i, is_store_i, ea_i, store_data_i   memory-op info, sampled in EXECUTE
//   branch_taken_i, branch_tgt_i, halt_i       control-flow info, sampled in WRITEBACK
//   stage_o         0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 5 HALT
//   pc_o, ir_o      PC and instruction word of the current instruction
//   load_data_o     data captured by the last load
//   rf_we_o         register-file write strobe (WRITEBACK, non-store only)
//   retire_o        one-cycle pulse during WRITEBACK
//   fault_o         sticky misaligned branch-target fault
//   instret_o       retired-instruction count (wraps)
module cpu_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_sequencer_if.master      mem_io,
    input  logic                 is_mem_i,
    input  logic                 is_store_i,
    input  logic [XLEN-1:0]      ea_i,
    input  logic [XLEN-1:0]      store_data_i,
    input  logic                 branch_taken_i,
    input  logic [XLEN-1:0]      branch_tgt_i,
    input  logic                 halt_i,
    output logic [2:0]           stage_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [31:0]          ir_o,
    output logic [XLEN-1:0]      load_data_o,
    output logic                 rf_we_o,
    output logic                 retire_o,
    output logic                 fault_o,
    output logic [CNT_W-1:0]     instret_o
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5
    } stage_e;

    stage_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   load_q;
    logic              store_q;
    logic              rf_we_q;
    logic              retire_q;
    logic              fault_q;
    logic [CNT_W-1:0]  instret_q;
    logic [XLEN-1:0]   next_pc;

    always_comb begin
        next_pc = branch_taken_i ? branch_tgt_i : pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_VECTOR;
            ir_q      <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            load_q    <= '0;
            store_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            // Strobes are set only on the edge entering WRITEBACK, so they cover exactly that cycle.
            rf_we_q  <= 1'b0;
            retire_q <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (!req_q) begin
                        // Bubble after reset: issue the first fetch from the reset PC.
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pc_q;
                    end else if (mem_io.mem_ack) begin
                        ir_q    <= mem_io.mem_rdata[31:0];
                        req_q   <= 1'b0;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    state_q <= StExecute;
                end
                StExecute: begin
                    store_q <= is_mem_i & is_store_i;
                    if (is_mem_i) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store_i;
                        addr_q  <= ea_i;
                        wdata_q <= store_data_i;
                        state_q <= StMemory;
                    end else begin
                        retire_q <= 1'b1;
                        rf_we_q  <= 1'b1;
                        state_q  <= StWriteback;
                    end
                end
                StMemory: begin
                    if (req_q && mem_io.mem_ack) begin
                        req_q <= 1'b0;
                        if (!store_q) begin
                            load_q <= mem_io.mem_rdata;
                        end
                        retire_q <= 1'b1;
                        rf_we_q  <= ~store_q;
                        state_q  <= StWriteback;
                    end
                end
                StWriteback: begin
                    instret_q <= instret_q + CNT_W'(1);
                    if (branch_taken_i && (branch_tgt_i[1:0] != 2'b00)) begin
                        // Misaligned target: keep the faulting PC visible and stop.
                        fault_q <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        pc_q <= next_pc;
                        if (halt_i) begin
                            state_q <= StHalt;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= next_pc;
                            state_q <= StFetch;
                        end
                    end
                end
                StHalt: begin
                end
                default: begin
                    // Unreachable encodings: park safely and flag it.
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    fault_q <= 1'b1;
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign mem_io.mem_req   = req_q;
    assign mem_io.mem_we    = we_q;
    assign mem_io.mem_addr  = addr_q;
    assign mem_io.mem_wdata = wdata_q;

    assign stage_o     = state_q;
    assign pc_o        = pc_q;
    assign ir_o        = ir_q;
    assign load_data_o = load_q;
    assign rf_we_o     = rf_we_q;
    assign retire_o    = retire_q;
    assign fault_o     = fault_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases followed by random instructions with
// random wait states, checked at every cycle against an instruction-level reference model.
module tb_cpu_sequencer;
    localparam int unsigned     XLEN = 32;
    localparam int unsigned     CNT_W = 4;
    localparam logic [31:0]     RV = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic is_mem_i = 0, is_store_i = 0, branch_taken_i = 0, halt_i = 0;
    logic [31:0] ea_i = '0, store_data_i = '0, branch_tgt_i = '0;
    logic [2:0]  stage_o;
    logic [31:0] pc_o, ir_o, load_data_o;
    logic        rf_we_o, retire_o, fault_o;
    logic [CNT_W-1:0] instret_o;

    cpu_sequencer_if #(.XLEN(XLEN)) bus ();

    cpu_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mem_io(bus),
        .is_mem_i(is_mem_i), .is_store_i(is_store_i), .ea_i(ea_i), .store_data_i(store_data_i),
        .branch_taken_i(branch_taken_i), .branch_tgt_i(branch_tgt_i), .halt_i(halt_i),
        .stage_o(stage_o), .pc_o(pc_o), .ir_o(ir_o), .load_data_o(load_data_o),
        .rf_we_o(rf_we_o), .retire_o(retire_o), .fault_o(fault_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] exp_pc, exp_ir, exp_load;
    int          exp_instret;
    logic        exp_fault;
    bit          halted;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_pc = RV; exp_ir = '0; exp_load = '0; exp_instret = 0; exp_fault = 1'b0; halted = 0;
    endtask

    task automatic check_idle_regs(input string tag);
        check_eq({tag, "_stage"}, 64'(stage_o), 64'd0);
        check_eq({tag, "_pc"}, 64'(pc_o), 64'(RV));
        check_eq({tag, "_req"}, 64'(bus.mem_req), 64'd0);
        check_eq({tag, "_instret"}, 64'(instret_o), 64'(exp_instret));
    endtask

    task automatic apply_reset();
        bus.mem_ack = 1'b0;
        reset = 1'b0;
        step();
        step();
        model_reset();
        check_idle_regs("rst");
        check_eq("rst_ir", 64'(ir_o), 64'd0);
        check_eq("rst_misc", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                 {1'b0, 32'd0, 32'd0});
        check_eq("rst_out", {load_data_o, fault_o, rf_we_o, retire_o}, '0);
        reset = 1'b1;
    endtask

    task automatic halt_check();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            step();
            check_eq("halt_stage", 64'(stage_o), 64'd5);
            check_eq("halt_req", 64'(bus.mem_req), 64'd0);
            check_eq("halt_pc", 64'(pc_o), 64'(exp_pc));
            check_eq("halt_state", {instret_o, fault_o, retire_o},
                     {4'(exp_instret), exp_fault, 1'b0});
        end
        bus.mem_ack = 1'b0;
    endtask

    // Runs one instruction through the DUT, starting at a negedge while the DUT is in FETCH.
    task automatic run_instr(input logic mem, input logic st, input logic [31:0] ea,
                             input logic [31:0] sdata, input logic br, input logic [31:0] tgt,
                             input logic hlt, input int fwait, input int mwait,
                             input logic [31:0] idata, input logic [31:0] rdata, input bit abort);
        int n = 0;
        logic [31:0] nxt;
        while (!bus.mem_req && n < 4) begin
            bus.mem_ack = 1'($urandom_range(0, 1)); // ignored while no request is out
            step();
            n++;
        end
        bus.mem_ack = 1'b0;
        check_eq("fetch_req", 64'(bus.mem_req), 64'd1);
        check_eq("fetch_addr", 64'(bus.mem_addr), 64'(exp_pc));
        check_eq("fetch_we_stage", {bus.mem_we, stage_o, retire_o}, {1'b0, 3'd0, 1'b0});
        for (int w = 0; w < fwait; w++) begin
            bus.mem_rdata = $urandom;
            step();
            check_eq("fwait_hold", {bus.mem_req, bus.mem_addr, stage_o}, {1'b1, exp_pc, 3'd0});
            check_eq("fwait_ir", 64'(ir_o), 64'(exp_ir));
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = idata;
        step();
        exp_ir = idata;
        bus.mem_ack = 1'($urandom_range(0, 1)); // spurious ack during DECODE
        bus.mem_rdata = $urandom;
        check_eq("dec_stage", 64'(stage_o), 64'd1);
        check_eq("dec_ir", 64'(ir_o), 64'(idata));
        check_eq("dec_req", 64'(bus.mem_req), 64'd0);
        step();
        bus.mem_ack = 1'b0;
        check_eq("exe_stage", 64'(stage_o), 64'd2);
        check_eq("exe_ir", 64'(ir_o), 64'(idata));
        is_mem_i = mem; is_store_i = st; ea_i = ea; store_data_i = sdata;
        step();
        is_mem_i = 1'($urandom_range(0, 1)); is_store_i = 1'($urandom_range(0, 1));
        ea_i = $urandom; store_data_i = $urandom;
        if (mem) begin
            check_eq("mem_stage", 64'(stage_o), 64'd3);
            check_eq("mem_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                     {1'b1, st, ea, sdata});
            for (int w = 0; w < mwait; w++) begin
                step();
                check_eq("mwait_hold", {bus.mem_req, bus.mem_we, bus.mem_addr, stage_o},
                         {1'b1, st, ea, 3'd3});
            end
            if (abort) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_idle_regs("abort");
                step();
                reset = 1'b1;
                return;
            end
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rdata;
            step();
            bus.mem_ack = 1'b0;
            if (!st) exp_load = rdata;
        end
        check_eq("wb_stage", 64'(stage_o), 64'd4);
        check_eq("wb_strobes", {retire_o, rf_we_o}, {1'b1, !(mem && st)});
        check_eq("wb_load", 64'(load_data_o), 64'(exp_load));
        check_eq("wb_pc_instret", {pc_o, instret_o}, {exp_pc, 4'(exp_instret)});
        check_eq("wb_req_fault", {bus.mem_req, fault_o}, {1'b0, exp_fault});
        branch_taken_i = br; branch_tgt_i = tgt; halt_i = hlt;
        step();
        branch_taken_i = 1'b0; halt_i = 1'b0; branch_tgt_i = $urandom;
        exp_instret = (exp_instret + 1) % 16;
        nxt = br ? tgt : exp_pc + 32'd4;
        if (br && tgt[1:0] != 2'b00) begin
            exp_fault = 1'b1;
            halted = 1;
        end else begin
            exp_pc = nxt;
            halted = hlt;
        end
        check_eq("post_wb_stage", 64'(stage_o), halted ? 64'd5 : 64'd0);
        check_eq("post_wb_pc", 64'(pc_o), 64'(exp_pc));
        check_eq("post_wb_cnt", {instret_o, fault_o, retire_o, rf_we_o},
                 {4'(exp_instret), exp_fault, 2'b00});
        if (halted) check_eq("post_wb_noreq", 64'(bus.mem_req), 64'd0);
        else check_eq("post_wb_fetch", {bus.mem_req, bus.mem_we, bus.mem_addr},
                      {1'b1, 1'b0, exp_pc});
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        model_reset();
        apply_reset();
        // Plain ALU op, zero-wait.
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0010_0093, 0, 0);
        // Fetch delayed three cycles.
        run_instr(0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h1234_5678, 0, 0);
        // Load then store (store must leave load data alone).
        run_instr(1, 0, 32'h2000, 0, 0, 0, 0, 0, 0, 32'h0000_2003, 32'hDEAD_BEEF, 0);
        run_instr(1, 1, 32'h3000, 32'h55, 0, 0, 0, 1, 2, 32'h0000_2023, 32'h1111_1111, 0);
        // Aligned branch, then misaligned branch faults and halts.
        run_instr(0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h0000_0063, 0, 0);
        run_instr(0, 0, 0, 0, 1, 32'h42, 0, 0, 0, 32'h0000_0063, 0, 0);
        halt_check();
        apply_reset();
        // Reset while waiting in MEMORY.
        run_instr(1, 0, 32'h2000, 0, 0, 0, 0, 0, 2, 32'h0000_2003, 0, 1);
        // Random instruction stream; instret wraps repeatedly at CNT_W=4.
        for (int k = 0; k < 150; k++) begin
            logic        m, s, b, h;
            logic [31:0] t;
            m = ($urandom_range(0, 9) < 4);
            s = m & 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0);
            t = $urandom & 32'hFFFF_FFFC;
            if (b && $urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            h = ($urandom_range(0, 19) == 0);
            run_instr(m, s, $urandom, $urandom, b, t, h, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom, $urandom, m && ($urandom_range(0, 29) == 0));
            if (halted) begin
                halt_check();
                apply_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
